// File: rtl/div_acc.sv
// div_acc: iterative divider accelerator placed after the core controller.
// It replaces a software repeated-subtraction divide loop. It computes the
// loop's end state: quotient counter -> M[Q_ADDR], residue -> M[R_ADDR] and D.
// The core stalls while the operation is in flight.
//
// Optional build macro: DIV_ZERO_GUARD_EN
//   defined   : a zero divisor at start is refused. DivErr pulses and the core
//               runs the loop natively.
//   undefined : DivErr is tied low. A zero divisor runs the normal sequence and
//               writes Q=0, R=Divident, which is not an architectural result.
//
// Handshake: StartDiv102 is a single-cycle request. It is accepted only in IDLE
// with Abort low. Results appear as one write strobe per cycle (WRQ, then WRR),
// and DivDone marks the final write. The core has no ready/backpressure path;
// it is held off through DivStall instead.

module div_acc #(
  parameter int              DATA_W       = 16,
  parameter int              BITS_PER_CYC = 1,
  parameter logic [DATA_W-1:0] Q_ADDR     = 16'd1,
  parameter logic [DATA_W-1:0] R_ADDR     = 16'd2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              StartDiv102,
  input  logic [DATA_W-1:0] Divident,
  input  logic [DATA_W-1:0] Divisor,
  input  logic              Abort,
  output logic              DivStall,
  output logic              DivBusy,
  output logic              DivMemWrEn,
  output logic [DATA_W-1:0] DivMemAddr,
  output logic [DATA_W-1:0] DivMemWrData,
  output logic              DivDWrEn,
  output logic [DATA_W-1:0] DivDData,
  output logic              DivDone,
  output logic              DivErr
);

  localparam int ITERS = DATA_W / BITS_PER_CYC;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CALC = 3'd1,
    FIX  = 3'd2,
    WRQ  = 3'd3,
    WRR  = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  // Operand latches. The dividend is kept unshifted for the FIX zero test.
  logic [DATA_W-1:0] n_reg;
  logic [DATA_W-1:0] d_reg;
  // Division working set: dividend shifter, quotient shifter, and the
  // remainder with one guard bit.
  logic [DATA_W-1:0] n_sh;
  logic [DATA_W-1:0] q_sh;
  logic [DATA_W:0]   r_sh;
  logic [CNT_W-1:0]  cnt;
  // Residue after FIX, held for the WRR cycle.
  logic [DATA_W-1:0] r_fix;

  logic              start_ok;
  logic              err_next;

  logic [DATA_W-1:0] step_n;
  logic [DATA_W-1:0] step_q;
  logic [DATA_W:0]   step_r;
  logic [DATA_W:0]   shifted;

  logic [DATA_W-1:0] fix_q;
  logic [DATA_W-1:0] fix_r;

  assign start_ok = StartDiv102 & ~Abort;

  // Core freeze: this is asserted in the start cycle itself, before busy registers.
  assign DivStall = StartDiv102 | DivBusy;

  // Restoring division step, MSB first. This resolves BITS_PER_CYC quotient bits.
  always_comb begin
    step_n  = n_sh;
    step_q  = q_sh;
    step_r  = r_sh;
    shifted = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) begin
      shifted = {step_r[DATA_W-1:0], step_n[DATA_W-1]};
      step_n  = {step_n[DATA_W-2:0], 1'b0};
      if (shifted >= {1'b0, d_reg}) begin
        step_r = shifted - {1'b0, d_reg};
        step_q = {step_q[DATA_W-2:0], 1'b1};
      end else begin
        step_r = shifted;
        step_q = {step_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Convert floor division into the loop's result: the smallest k>=1 with N-k*D<=0.
  always_comb begin
    fix_q = q_sh + 1'b1;
    fix_r = r_sh[DATA_W-1:0] - d_reg;
    if ((r_sh == '0) && (n_reg != '0)) begin
      fix_q = q_sh;
      fix_r = '0;
    end
  end

  // Next-state logic. Abort overrides every non-IDLE state.
  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
`ifdef DIV_ZERO_GUARD_EN
          if (Divisor == '0) begin
            err_next = 1'b1;
          end else begin
            state_next = CALC;
          end
`else
          state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (cnt == LAST_C) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = WRQ;
      WRQ:     state_next = WRR;
      WRR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (Abort && (state != IDLE)) begin
      state_next = IDLE;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operand capture, iteration, and FIX result capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      n_reg <= '0;
      d_reg <= '0;
      n_sh  <= '0;
      q_sh  <= '0;
      r_sh  <= '0;
      cnt   <= '0;
      r_fix <= '0;
    end else begin
      if ((state == IDLE) && (state_next == CALC)) begin
        n_reg <= Divident;
        d_reg <= Divisor;
        n_sh  <= Divident;
        q_sh  <= '0;
        r_sh  <= '0;
        cnt   <= ITERS_C;
      end else if (state == CALC) begin
        n_sh <= step_n;
        q_sh <= step_q;
        r_sh <= step_r;
        cnt  <= cnt - 1'b1;
      end
      if (state == FIX) begin
        r_fix <= fix_r;
      end
    end
  end

  // Registered outputs are driven from the next state, so they line up with
  // the state they belong to. Data outputs hold between writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DivBusy      <= 1'b0;
      DivMemWrEn   <= 1'b0;
      DivMemAddr   <= '0;
      DivMemWrData <= '0;
      DivDWrEn     <= 1'b0;
      DivDData     <= '0;
      DivDone      <= 1'b0;
    end else begin
      DivBusy    <= (state_next != IDLE);
      DivMemWrEn <= (state_next == WRQ) || (state_next == WRR);
      DivDWrEn   <= (state_next == WRR);
      DivDone    <= (state_next == WRR);
      if (state_next == WRQ) begin
        DivMemAddr   <= Q_ADDR;
        DivMemWrData <= fix_q;
      end
      if (state_next == WRR) begin
        DivMemAddr   <= R_ADDR;
        DivMemWrData <= r_fix;
        DivDData     <= r_fix;
      end
    end
  end

`ifdef DIV_ZERO_GUARD_EN
  // One-cycle divide-by-zero indication for a refused start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      DivErr <= 1'b0;
    end else begin
      DivErr <= err_next;
    end
  end
`else
  assign DivErr = 1'b0;
  logic unused_err;
  assign unused_err = err_next;
`endif

endmodule

// File: tb/tb_div_acc.sv
// tb_div_acc: directed checks of div_acc covering reset, latency, results,
// ignored restart, abort, mid-operation reset, and the zero divisor.

module tb_div_acc;

  localparam logic [15:0] Q_ADDR = 16'd1;
  localparam logic [15:0] R_ADDR = 16'd2;

  logic        Clk;
  logic        Reset;
  logic        StartDiv102;
  logic [15:0] Divident;
  logic [15:0] Divisor;
  logic        Abort;
  logic        DivStall;
  logic        DivBusy;
  logic        DivMemWrEn;
  logic [15:0] DivMemAddr;
  logic [15:0] DivMemWrData;
  logic        DivDWrEn;
  logic [15:0] DivDData;
  logic        DivDone;
  logic        DivErr;

  int total = 0;
  int bad   = 0;

  // Write records: {kind, addr, data}. Kind 1 is a memory write, kind 2 is a D write.
  logic [33:0] exp_q[$];
  logic [33:0] obs_q[$];

  div_acc dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .StartDiv102  (StartDiv102),
    .Divident     (Divident),
    .Divisor      (Divisor),
    .Abort        (Abort),
    .DivStall     (DivStall),
    .DivBusy      (DivBusy),
    .DivMemWrEn   (DivMemWrEn),
    .DivMemAddr   (DivMemAddr),
    .DivMemWrData (DivMemWrData),
    .DivDWrEn     (DivDWrEn),
    .DivDData     (DivDData),
    .DivDone      (DivDone),
    .DivErr       (DivErr)
  );

  // Clock and watchdog
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Write monitor, sampled away from the active edge
  always @(negedge Clk) begin
    if (DivMemWrEn) obs_q.push_back({2'd1, DivMemAddr, DivMemWrData});
    if (DivDWrEn)   obs_q.push_back({2'd2, 16'd0, DivDData});
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%04h expected=%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check32(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check34(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%09h expected=%09h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard drain: the observed writes must equal the expected writes, in order.
  task automatic sb_check(input string tag);
    int n;
    check32({tag, "_wr_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check34({tag, "_wr_rec"}, obs_q[i], exp_q[i]);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Full operation from period 0 (start) through period 20. Each cycle is checked
  // against the expected timeline. A second start can be injected at second_k.
  task automatic run_div(input logic [15:0] n, input logic [15:0] d,
                         input logic [15:0] eq, input logic [15:0] er,
                         input int second_k);
    StartDiv102 = 1'b1;
    Divident    = n;
    Divisor     = d;
    exp_q.push_back({2'd1, Q_ADDR, eq});
    exp_q.push_back({2'd1, R_ADDR, er});
    exp_q.push_back({2'd2, 16'd0, er});
    for (int k = 0; k <= 20; k++) begin
      @(negedge Clk);
      check1("stall", DivStall, k <= 19);
      check1("busy", DivBusy, (k >= 1) && (k <= 19));
      check1("mem_wr_en", DivMemWrEn, (k == 18) || (k == 19));
      check1("d_wr_en", DivDWrEn, k == 19);
      check1("done", DivDone, k == 19);
      check1("err", DivErr, 1'b0);
      if (k == 18) begin
        check16("wrq_addr", DivMemAddr, Q_ADDR);
        check16("wrq_data", DivMemWrData, eq);
      end
      if (k == 19) begin
        check16("wrr_addr", DivMemAddr, R_ADDR);
        check16("wrr_data", DivMemWrData, er);
        check16("d_data", DivDData, er);
      end
      tick();
      StartDiv102 = (k + 1 == second_k);
      if (k + 1 == second_k) begin
        Divident = 16'd100;
        Divisor  = 16'd3;
      end
    end
  endtask

  initial begin
    // Reset
    Reset       = 1'b1;
    StartDiv102 = 1'b0;
    Divident    = '0;
    Divisor     = '0;
    Abort       = 1'b0;
    repeat (3) tick();
    @(negedge Clk);
    check1("rst_busy", DivBusy, 1'b0);
    check1("rst_stall", DivStall, 1'b0);
    check1("rst_mem_wr_en", DivMemWrEn, 1'b0);
    check16("rst_addr", DivMemAddr, 16'h0000);
    check16("rst_data", DivMemWrData, 16'h0000);
    check1("rst_d_wr_en", DivDWrEn, 1'b0);
    check16("rst_d_data", DivDData, 16'h0000);
    check1("rst_done", DivDone, 1'b0);
    check1("rst_err", DivErr, 1'b0);
    tick();
    Reset = 1'b0;
    tick();

    // Exact quotient
    run_div(16'd20000, 16'd10, 16'd2000, 16'h0000, -1);
    sb_check("t1");

    // Inexact quotient: the residue wraps negative
    run_div(16'd7, 16'd2, 16'd4, 16'hFFFF, -1);
    sb_check("t2");

    // Reset mid-operation clears everything, including held data outputs
    StartDiv102 = 1'b1;
    Divident    = 16'd100;
    Divisor     = 16'd3;
    tick();
    StartDiv102 = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    @(negedge Clk);
    check1("midrst_stall_before", DivStall, 1'b1);
    tick();
    @(negedge Clk);
    check1("midrst_busy", DivBusy, 1'b0);
    check16("midrst_addr", DivMemAddr, 16'h0000);
    check16("midrst_d_data", DivDData, 16'h0000);
    tick();
    Reset = 1'b0;
    repeat (20) begin
      @(negedge Clk);
      check1("midrst_idle_busy", DivBusy, 1'b0);
      tick();
    end
    sb_check("midrst");

    // Zero dividend, then the largest dividend with divisor 1
    run_div(16'd0, 16'd5, 16'd1, 16'hFFFB, -1);
    run_div(16'd32767, 16'd1, 16'd32767, 16'h0000, -1);
    sb_check("t3");

    // A start while busy is ignored
    run_div(16'd20000, 16'd10, 16'd2000, 16'h0000, 5);
    sb_check("t4");

    // Abort at T+8 returns to IDLE at T+9; a new start at T+10 then completes
    StartDiv102 = 1'b1;
    Divident    = 16'd20000;
    Divisor     = 16'd10;
    for (int k = 0; k <= 9; k++) begin
      @(negedge Clk);
      check1("abort_stall", DivStall, k <= 8);
      check1("abort_busy", DivBusy, (k >= 1) && (k <= 8));
      check1("abort_mem_wr_en", DivMemWrEn, 1'b0);
      check1("abort_done", DivDone, 1'b0);
      tick();
      StartDiv102 = 1'b0;
      Abort       = (k + 1 == 8);
    end
    run_div(16'd7, 16'd2, 16'd4, 16'hFFFF, -1);
    sb_check("t5");

    // Zero divisor
`ifdef DIV_ZERO_GUARD_EN
    StartDiv102 = 1'b1;
    Divident    = 16'd9;
    Divisor     = 16'd0;
    @(negedge Clk);
    check1("dz_stall0", DivStall, 1'b1);
    tick();
    StartDiv102 = 1'b0;
    @(negedge Clk);
    check1("dz_err", DivErr, 1'b1);
    check1("dz_busy", DivBusy, 1'b0);
    check1("dz_stall1", DivStall, 1'b0);
    tick();
    repeat (20) begin
      @(negedge Clk);
      check1("dz_err_low", DivErr, 1'b0);
      check1("dz_busy_low", DivBusy, 1'b0);
      tick();
    end
`else
    run_div(16'd9, 16'd0, 16'h0000, 16'd9, -1);
`endif
    sb_check("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_acc.md
Name: div_acc

Overview:
- Iterative divider accelerator, directly downstream of the core controller.
- Consumes the controller's divide-loop detection: the start pulse plus the captured dividend and divisor immediates.
- Computes the exact architectural end state of the software repeated-subtraction loop (M[1] quotient counter, M[2] residue, D register), stalling the core meanwhile.
- Writes results through the core's memory/D write mux, so the loop completes without executing its iterations.

Parameters:
DATA_W, 16, operand/result width (Hack word)
BITS_PER_CYC, 1, quotient bits resolved per CALC cycle; legal 1 or 2
Q_ADDR, 16'd1, memory address receiving the quotient counter
R_ADDR, 16'd2, memory address receiving the residue

Ports:
Clk  in  1  core clock
Reset  in  1  synchronous, active-high reset
StartDiv102  in  1  one-cycle start pulse from the controller
Divident  in  DATA_W  dividend, sampled with start; bit15=0 guaranteed
Divisor  in  DATA_W  divisor, sampled with start; bit15=0 guaranteed
Abort  in  1  pipeline flush (jump/redirect); cancels the operation
DivStall  out  1  freeze fetch/decode/PC
DivBusy  out  1  operation in flight
DivMemWrEn  out  1  memory write strobe
DivMemAddr  out  DATA_W  memory write address
DivMemWrData  out  DATA_W  memory write data
DivDWrEn  out  1  D register write strobe
DivDData  out  DATA_W  D register write data
DivDone  out  1  one-cycle completion pulse
DivErr  out  1  one-cycle divide-by-zero pulse (macro only; else tied 0)

Behaviour:
- Reset: state IDLE; all strobes, DivBusy, DivDone and DivErr are 0; data outputs are 0; internal registers are cleared.
- FSM states: IDLE, CALC, FIX, WRQ, WRR.
- IDLE:
  - StartDiv102=1 with Abort=0: latch N=Divident and D=Divisor, clear the quotient/remainder shift registers, set the iteration counter to DATA_W/BITS_PER_CYC, and go to CALC.
- CALC:
  - Restoring division, MSB first, BITS_PER_CYC bits per cycle.
  - The counter decrements each cycle; on the last cycle go to FIX.
  - The remainder register is DATA_W+1 bits (one guard bit); the trial subtract is unsigned.
- FIX: match the software loop semantics (Q=k, the smallest k>=1 with N-k*D<=0; R=N-k*D).
  - If r==0 and N!=0: Q=q, R=0.
  - Otherwise: Q=q+1, R=r-D, a two's-complement DATA_W result that wraps negative.
  - Go to WRQ.
- WRQ: DivMemWrEn=1, DivMemAddr=Q_ADDR, DivMemWrData=Q. Go to WRR.
- WRR:
  - DivMemWrEn=1, DivMemAddr=R_ADDR, DivMemWrData=R.
  - DivDWrEn=1, DivDData=R.
  - DivDone=1. Go to IDLE.
- Latency:
  - Start in cycle T: CALC occupies T+1..T+DATA_W/BITS_PER_CYC.
  - FIX follows, then WRQ, then WRR.
  - Defaults: WRR at T+19.
- Outputs outside their write states:
  - DivMemWrEn, DivDWrEn and DivDone are 0.
  - Data outputs hold their last value.
- DivBusy = (state != IDLE), registered.
- DivStall = StartDiv102 | DivBusy (combinational), so the core freezes in the start cycle itself.
- StartDiv102 while busy: ignored; no re-latch.
- Abort in any non-IDLE state, or in IDLE coincident with start:
  - Next state is IDLE.
  - No writes and no DivDone.
  - Abort in WRR does not suppress that cycle's writes; it is already committed.
- Reset mid-operation: same as Abort, plus registers cleared.
- Back-to-back: a start in the cycle after WRR (state IDLE) is accepted.

Optional Feature:
DIV_ZERO_GUARD_EN
- Enabled, Divisor==0 at start:
  - No CALC and no writes.
  - The FSM stays in IDLE and pulses DivErr for one cycle.
  - DivStall is high only in the start cycle.
  - The core then executes the software loop natively.
- Disabled:
  - DivErr is tied 0.
  - Divisor 0 runs the normal sequence and writes Q=16'h0000 and R=Divident (q=0xFFFF+1 wraps; r-0=N).
  - This result is documented as non-architectural.

Test Plan:
1. Divident=20000, Divisor=10, start -> WRQ writes M[1]=2000; WRR writes M[2]=0 and D=0; DivDone at T+19; DivStall high T..T+19.
2. Divident=7, Divisor=2 -> Q=4, R=16'hFFFF, D=16'hFFFF.
3. Divident=0, Divisor=5 -> Q=1, R=16'hFFFB; Divident=32767, Divisor=1 -> Q=32767, R=0.
4. Start 20000/10, second start 100/3 at T+5 -> second ignored; results 2000/0 only.
5. Start 20000/10, Abort at T+8 -> IDLE at T+9; no DivMemWrEn, DivDWrEn or DivDone through T+25; new start 7/2 at T+10 completes correctly.
6. Divisor=0, Divident=9:
   - With DIV_ZERO_GUARD_EN: DivErr pulse, no writes, DivBusy stays 0.
   - Without it: writes M[1]=0, M[2]=9.
